// File: rtl/stream_mux_rr.sv
// rtl/stream_mux_rr.sv - N-channel packet-atomic stream mux with round-robin or fixed-priority arbitration
module stream_mux_rr #(
  parameter int WIDTH       = 8,
  parameter int N           = 4,
  parameter bit ROUND_ROBIN = 1'b1,
  parameter int SELW        = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         in_valid,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_last,
  output logic [N-1:0]         in_ready,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_last,
  output logic [SELW-1:0]      out_sel,
  input  logic                 out_ready
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t            state_q, state_d;
  logic [SELW-1:0]   lock_ch_q, lock_ch_d;
  logic [SELW-1:0]   ptr_q, ptr_d;
  logic [SELW-1:0]   sel;
  logic [SELW-1:0]   idx_s;
  int                idx;
  logic              granted;
  logic              can_load;
  logic              accept;
  logic              sel_last;
  logic [WIDTH-1:0]  sel_data;

  assign can_load = !out_valid || out_ready;
  assign accept   = |(in_valid & in_ready);

  // Arbitration: a locked channel owns the output outright; otherwise pick the first valid channel
  always_comb begin
    sel     = '0;
    granted = 1'b0;
    idx     = 0;
    idx_s   = '0;
    if (state_q == LOCKED) begin
      sel     = lock_ch_q;
      granted = 1'b1;
    end else begin
      for (int j = 0; j < N; j++) begin
        idx = ROUND_ROBIN ? int'(ptr_q) + j : j;
        if (idx >= N) idx = idx - N;
        idx_s = SELW'(idx);
        if (!granted && in_valid[idx_s]) begin
          sel     = idx_s;
          granted = 1'b1;
        end
      end
    end
  end

  // Ready goes only to the selected channel, and only when the output register can take a beat
  always_comb begin
    in_ready = '0;
    if (rst_n && granted && can_load) in_ready[sel] = 1'b1;
  end

  // Steer the selected channel's payload toward the output register
  always_comb begin
    sel_data = '0;
    sel_last = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (SELW'(i) == sel) begin
        sel_data = in_data[i*WIDTH +: WIDTH];
        sel_last = in_last[i];
      end
    end
  end

  // Lock state, locked channel and round-robin pointer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      lock_ch_q <= '0;
      ptr_q     <= '0;
    end else begin
      state_q   <= state_d;
      lock_ch_q <= lock_ch_d;
      ptr_q     <= ptr_d;
    end
  end

  // Lock on a non-final beat, unlock and advance the pointer past the winner on its final beat
  always_comb begin
    state_d   = state_q;
    lock_ch_d = lock_ch_q;
    ptr_d     = ptr_q;
    if (accept) begin
      if (sel_last) begin
        state_d = IDLE;
        if (ROUND_ROBIN) ptr_d = (sel == SELW'(N-1)) ? '0 : sel + 1'b1;
      end else begin
        state_d   = LOCKED;
        lock_ch_d = sel;
      end
    end
  end

  // Output register: load on every accepted beat, drain when the consumer takes the beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_sel   <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= sel_data;
      out_last  <= sel_last;
      out_sel   <= sel;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stream_mux_rr.sv
// tb/tb_stream_mux_rr.sv - randomized and directed check of stream_mux_rr against a behavioural model
module tb_stream_mux_rr;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n     [2];
  logic [3:0]  in_valid  [2];
  logic [31:0] in_data   [2];
  logic [3:0]  in_last   [2];
  logic [3:0]  in_ready  [2];
  logic        out_valid [2];
  logic [7:0]  out_data  [2];
  logic        out_last  [2];
  logic [1:0]  out_sel   [2];
  logic        out_ready [2];

  stream_mux_rr #(.WIDTH(8), .N(4), .ROUND_ROBIN(1'b1)) dut_rr (
    .clk(clk), .rst_n(rst_n[0]), .in_valid(in_valid[0]), .in_data(in_data[0]),
    .in_last(in_last[0]), .in_ready(in_ready[0]), .out_valid(out_valid[0]),
    .out_data(out_data[0]), .out_last(out_last[0]), .out_sel(out_sel[0]),
    .out_ready(out_ready[0])
  );

  stream_mux_rr #(.WIDTH(8), .N(4), .ROUND_ROBIN(1'b0)) dut_fp (
    .clk(clk), .rst_n(rst_n[1]), .in_valid(in_valid[1]), .in_data(in_data[1]),
    .in_last(in_last[1]), .in_ready(in_ready[1]), .out_valid(out_valid[1]),
    .out_data(out_data[1]), .out_last(out_last[1]), .out_sel(out_sel[1]),
    .out_ready(out_ready[1])
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Model state: index 0 models the round-robin instance, index 1 the fixed-priority one
  bit        m_lock [2];
  int        m_ch   [2];
  int        m_ptr  [2];
  bit        m_ov   [2];
  logic [7:0] m_od  [2];
  bit        m_ol   [2];
  int        m_os   [2];
  int        acc_ch [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int d, input int i, input bit v, input logic [7:0] dat, input bit l);
    in_valid[d][i]       = v;
    in_data[d][i*8 +: 8] = dat;
    in_last[d][i]        = l;
  endtask

  // Compare every cycle against the model, then advance the model to the next clock edge
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      bit         found;
      bit         canl;
      bit         acc;
      int         s;
      logic [3:0] er;
      found = 1'b0;
      canl  = 1'b0;
      acc   = 1'b0;
      s     = 0;
      er    = 4'b0000;
      if (!rst_n[d]) begin
        m_lock[d] = 1'b0; m_ch[d] = 0; m_ptr[d] = 0;
        m_ov[d] = 1'b0; m_od[d] = 8'h00; m_ol[d] = 1'b0; m_os[d] = 0;
      end else begin
        if (m_lock[d]) begin
          s = m_ch[d];
          found = 1'b1;
        end else begin
          for (int j = 0; j < 4; j++) begin
            int c;
            c = (d == 0) ? (m_ptr[d] + j) % 4 : j;
            if (!found && in_valid[d][c]) begin
              s = c;
              found = 1'b1;
            end
          end
        end
        canl = !m_ov[d] || out_ready[d];
        if (found && canl) er[s] = 1'b1;
        acc = found && canl && in_valid[d][s];
      end
      chk($sformatf("d%0d in_ready", d), in_ready[d], er);
      chk($sformatf("d%0d out_valid", d), out_valid[d], m_ov[d]);
      if (m_ov[d] || !rst_n[d]) begin
        chk($sformatf("d%0d out_data", d), out_data[d], m_od[d]);
        chk($sformatf("d%0d out_last", d), out_last[d], m_ol[d]);
        chk($sformatf("d%0d out_sel", d), out_sel[d], m_os[d]);
      end
      acc_ch[d] = acc ? s : -1;
      if (rst_n[d]) begin
        if (acc) begin
          m_ov[d] = 1'b1;
          m_od[d] = in_data[d][s*8 +: 8];
          m_ol[d] = in_last[d][s];
          m_os[d] = s;
          if (in_last[d][s]) begin
            m_lock[d] = 1'b0;
            if (d == 0) m_ptr[d] = (s + 1) % 4;
          end else begin
            m_lock[d] = 1'b1;
            m_ch[d]   = s;
          end
        end else if (out_ready[d]) begin
          m_ov[d] = 1'b0;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0; in_valid[d] = 4'b0; in_data[d] = 32'b0; in_last[d] = 4'b0;
      out_ready[d] = 1'b1; acc_ch[d] = -1;
    end
    repeat (3) tick();
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;

    // Reset / idle
    @(negedge clk);
    chk("idle out_valid", out_valid[0], 1'b0);
    chk("idle in_ready", in_ready[0], 4'b0000);
    chk("idle out_data", out_data[0], 8'h00);

    // Single beat on ch2
    set_ch(0, 2, 1'b1, 8'hA5, 1'b1);
    @(negedge clk);
    chk("single in_ready", in_ready[0], 4'b0100);
    tick();
    set_ch(0, 2, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    chk("single out_valid", out_valid[0], 1'b1);
    chk("single out_data", out_data[0], 8'hA5);
    chk("single out_sel", out_sel[0], 2'd2);
    chk("single out_last", out_last[0], 1'b1);
    chk("single model ptr", m_ptr[0], 3);
    tick();
    @(negedge clk);
    chk("single drained", out_valid[0], 1'b0);

    // Fresh reset, then round-robin fairness with 1-beat packets on every channel
    tick();
    rst_n[0] = 1'b0;
    tick();
    rst_n[0] = 1'b1;
    for (int i = 0; i < 4; i++) set_ch(0, i, 1'b1, 8'(8'h40 + i), 1'b1);
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      chk($sformatf("rr in_ready k%0d", k), in_ready[0], 32'(1 << (k % 4)));
      if (k > 0) begin
        chk($sformatf("rr out_sel k%0d", k), out_sel[0], (k - 1) % 4);
        chk($sformatf("rr out_valid k%0d", k), out_valid[0], 1'b1);
      end
      tick();
      set_ch(0, k % 4, 1'b1, 8'(8'h80 + k), 1'b1);
    end
    in_valid[0] = 4'b0000;
    tick();

    // Move the pointer to 1 with a single beat on ch0
    set_ch(0, 0, 1'b1, 8'h01, 1'b1);
    @(negedge clk);
    chk("ptr setup in_ready", in_ready[0], 4'b0001);
    tick();
    set_ch(0, 0, 1'b0, 8'h00, 1'b0);

    // Packet lock on ch1 with a bubble while ch0 and ch3 stay valid
    set_ch(0, 0, 1'b1, 8'h77, 1'b1);
    set_ch(0, 3, 1'b1, 8'h33, 1'b1);
    set_ch(0, 1, 1'b1, 8'h11, 1'b0);
    @(negedge clk);
    chk("lock first in_ready", in_ready[0], 4'b0010);
    tick();
    set_ch(0, 1, 1'b1, 8'h12, 1'b0);
    @(negedge clk);
    chk("lock b2 in_ready", in_ready[0], 4'b0010);
    chk("lock b1 data", out_data[0], 8'h11);
    chk("lock b1 sel", out_sel[0], 2'd1);
    tick();
    set_ch(0, 1, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    chk("lock bubble in_ready", in_ready[0], 4'b0010);
    chk("lock b2 data", out_data[0], 8'h12);
    chk("lock b2 sel", out_sel[0], 2'd1);
    tick();
    set_ch(0, 1, 1'b1, 8'h13, 1'b1);
    @(negedge clk);
    chk("lock b3 in_ready", in_ready[0], 4'b0010);
    chk("lock bubble out_valid", out_valid[0], 1'b0);
    tick();
    set_ch(0, 1, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    chk("next grant ch3", in_ready[0], 4'b1000);
    chk("lock b3 data", out_data[0], 8'h13);
    chk("lock b3 sel", out_sel[0], 2'd1);
    chk("lock b3 last", out_last[0], 1'b1);

    // Backpressure: three stalled cycles, then immediate reload
    tick();
    set_ch(0, 3, 1'b0, 8'h00, 1'b0);
    out_ready[0] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("stall data k%0d", k), out_data[0], 8'h33);
      chk($sformatf("stall in_ready k%0d", k), in_ready[0], 4'b0000);
      if (k < 2) tick();
    end
    tick();
    out_ready[0] = 1'b1;
    @(negedge clk);
    chk("unstall in_ready", in_ready[0], 4'b0001);
    tick();
    set_ch(0, 0, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    chk("unstall data", out_data[0], 8'h77);
    chk("unstall sel", out_sel[0], 2'd0);

    // Fixed priority: ch0 always beats ch3
    set_ch(1, 0, 1'b1, 8'hA0, 1'b1);
    set_ch(1, 3, 1'b1, 8'hB3, 1'b1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("fp in_ready k%0d", k), in_ready[1], 4'b0001);
      if (k > 0) chk($sformatf("fp out_sel k%0d", k), out_sel[1], 2'd0);
      tick();
      set_ch(1, 0, 1'b1, 8'(160 + k + 1), 1'b1);
    end

    // Reset in the middle of a ch0 packet
    set_ch(1, 0, 1'b1, 8'hC0, 1'b0);
    @(negedge clk);
    chk("fp pkt in_ready", in_ready[1], 4'b0001);
    tick();
    set_ch(1, 0, 1'b1, 8'hC1, 1'b0);
    @(negedge clk);
    chk("fp pkt out_data", out_data[1], 8'hC0);
    #3;
    rst_n[1] = 1'b0;
    #1;
    chk("midreset out_valid", out_valid[1], 1'b0);
    chk("midreset in_ready", in_ready[1], 4'b0000);
    set_ch(1, 0, 1'b0, 8'h00, 1'b0);
    repeat (2) tick();
    rst_n[1] = 1'b1;
    @(negedge clk);
    chk("post reset ch3 ready", in_ready[1], 4'b1000);
    tick();
    set_ch(1, 3, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    chk("post reset ch3 sel", out_sel[1], 2'd3);
    chk("post reset ch3 data", out_data[1], 8'hB3);

    // Randomized traffic on both instances with random backpressure and occasional resets
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
        if (cyc % 700 == 350) rst_n[d] = 1'b0;
        if (cyc % 700 == 352) rst_n[d] = 1'b1;
        out_ready[d] = ($urandom % 4) != 0;
        for (int i = 0; i < 4; i++) begin
          if (acc_ch[d] == i || !in_valid[d][i]) begin
            if ($urandom % 3 != 0)
              set_ch(d, i, 1'b1, 8'($urandom), ($urandom % 3) == 0);
            else
              set_ch(d, i, 1'b0, 8'h00, 1'b0);
          end
        end
      end
    end
    @(negedge clk);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/stream_mux_rr.md
Name: stream_mux_rr

Overview:
- N-channel, WIDTH-bit stream multiplexer with valid/ready handshakes on every input and on the output. It is the parametrised successor of the team's combinational 2:1 mux.
- Selection comes from an internal arbiter, either round-robin or fixed priority, not from a select pin.
- Packets stay atomic: once a channel wins, it keeps the output until its last beat is accepted.
- Single registered output stage; sits between multiple bus masters/producers and one shared consumer.

Parameters:
- WIDTH, 8, data bits per channel (>=1)
- N, 4, number of input channels (>=2)
- ROUND_ROBIN, 1, 1 = round-robin arbitration, 0 = fixed priority (channel 0 highest)
- SELW, $clog2(N), width of the channel index (derived; not to be overridden)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  N  per-channel beat valid
- in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_last  input  N  per-channel end-of-packet flag
- in_ready  output  N  per-channel beat accepted when valid&ready
- out_valid  output  1  output register holds a beat
- out_data  output  WIDTH  registered data
- out_last  output  1  registered end-of-packet flag
- out_sel  output  SELW  index of the channel that produced the current beat
- out_ready  input  1  consumer accepts the beat when out_valid&out_ready

Behaviour:
- Reset values (async on rst_n low):
  - out_valid = 0, out_data = 0, out_last = 0, out_sel = 0
  - lock = 0, rr pointer = 0
  - in_ready = 0 while rst_n is low
- can_load = !out_valid || out_ready.
  - The output register loads on any accepted input beat.
  - If it does not load and out_ready=1, out_valid clears.
- Selection:
  - Locked: sel = locked channel.
  - Unlocked, ROUND_ROBIN=1: sel = first i with in_valid[i], scanning from ptr upward modulo N.
  - Unlocked, ROUND_ROBIN=0: sel = lowest i with in_valid[i].
  - No in_valid while unlocked: no grant.
- in_ready[i] = can_load && granted && (sel==i). It is combinational from in_valid, out_valid and out_ready.
  - All non-selected channels see ready=0.
  - While locked, the locked channel's ready does not depend on its own valid.
- Latency: a beat accepted in cycle t appears on out_* in cycle t+1. Full throughput is one beat/cycle when out_ready is held at 1.
- Lock/state machine, two states:
  - IDLE -> LOCKED(k) on acceptance of a beat from channel k with last=0.
  - LOCKED(k) -> IDLE on acceptance of a beat from k with last=1.
  - An accepted single-beat packet (last=1) in IDLE stays IDLE.
  - While LOCKED, other channels' valids are ignored, even if channel k deasserts valid (bubbles allowed, lock held).
- RR pointer:
  - Updates only when a last=1 beat from channel k is accepted: ptr = (k+1) mod N, with wrap from N-1 to 0.
  - Unchanged when ROUND_ROBIN=0.
- Output stall: out_valid=1 && out_ready=0 holds out_* stable, and every in_ready is 0.
- Simultaneous events: out_ready=1 with a new accept in the same cycle replaces the register with the new beat; out_valid stays 1.
- Reset mid-packet: lock and ptr return to reset values. The partial packet is dropped, with no recovery beat.
- Upstream rule: in_valid/in_data/in_last are held stable until accepted. A violation is undefined but must not wedge the lock.

Test Plan (N=4, WIDTH=8 unless stated):
- Reset/idle: reset, then all in_valid=0 -> out_valid=0, in_ready=4'b0000, out_data=8'h00.
- Single beat: ch2 valid, data=8'hA5, last=1, out_ready=1 -> in_ready=4'b0100 at t; at t+1 out_valid=1, out_data=A5, out_sel=2, out_last=1; ptr becomes 3.
- RR fairness: all four channels continuously valid with 1-beat packets, out_ready=1 -> out_sel sequence 0,1,2,3,0,1 with no idle cycles.
- Packet lock:
  - ch1 sends 3 beats (11,12,13, last on 13) while ch0 and ch3 stay valid -> out_sel=1 for three consecutive beats, including a 1-cycle bubble on ch1.
  - Next grant goes to ch3 (ptr=2, first valid at or after ptr).
- Backpressure: out_ready=0 for 3 cycles with out_valid=1 -> out_data unchanged and in_ready=0. On out_ready=1, the next beat loads in the same cycle with no gap.
- Fixed priority and reset: ROUND_ROBIN=0 with ch0 and ch3 valid -> ch0 always wins. Assert rst_n low mid-packet on ch0 -> out_valid=0 immediately; after release ch3 can win.
